tdm_one_to_eight_demux: RTL

Receive-side counterpart of the 8:1 mux serializer. A serial TDM stream arrives one bit per enabled clock. Slot k of each frame carries bit k of the source byte. The block steers each bit into slot position k, reassembles the 8-bit frame and presents it with a one-cycle valid pulse. A frame-sync marker delimits slot 0, and a hunt/locked FSM tracks frame alignment.

---
 rtl/tdm_one_to_eight_demux_pkg.sv | 21 ++
 rtl/tdm_slot_counter.sv | 47 ++++
 rtl/tdm_one_to_eight_demux.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tdm_one_to_eight_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_one_to_eight_demux_pkg
//  Description : Shared definitions for the 8-slot TDM mux/demux pair.
//                Slot count, slot-index width and the frame-alignment state
//                encoding live here so both ends agree on slot ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_one_to_eight_demux_pkg;

    localparam int N_SLOTS = 8;
    localparam int SEL_W   = $clog2(N_SLOTS);

    // Frame-alignment tracker states
    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage : tdm_one_to_eight_demux_pkg
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_slot_counter
//  Description : Slot index counter for the TDM demux. Counts 0..N_SLOTS-1
//                and wraps; can be loaded to 1 (frame started by a sync bit)
//                or cleared to 0 (alignment lost).
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                inc       - advance to the next slot
//                load_one  - force the count to 1
//                clear     - force the count to 0
//                count     - current slot index
//                wrap      - high while count is the last slot of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
    import tdm_one_to_eight_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load_one,
    input  logic             clear,
    output logic [SEL_W-1:0] count,
    output logic             wrap
);

    logic [SEL_W-1:0] r_count;

    // Priority: reset, clear, load, increment. The increment relies on the
    // natural power-of-two rollover from N_SLOTS-1 back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load_one) begin
            r_count <= SEL_W'(1);
        end else if (inc) begin
            r_count <= r_count + SEL_W'(1);
        end
    end

    assign count = r_count;
    assign wrap  = (r_count == SEL_W'(N_SLOTS - 1));

endmodule : tdm_slot_counter
`default_nettype wire

// File: rtl/tdm_one_to_eight_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_one_to_eight_demux
//  Description : Receive-side 1:8 TDM demultiplexer. Serial bits arrive one
//                per enabled clock; bit k of each frame lands in dout[k].
//                A frame-sync marker flags slot 0 and a HUNT/LOCKED tracker
//                maintains frame alignment.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                en          - bit strobe qualifying din and frame_sync
//                din         - serial data bit for the current slot
//                frame_sync  - high with the slot-0 bit of every frame
//                dout        - last completed frame
//                frame_valid - one-cycle pulse when dout updates
//                sync_err    - one-cycle pulse on an alignment violation
//                locked      - high while aligned
//                slot        - index of the next slot expected
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_one_to_eight_demux
    import tdm_one_to_eight_demux_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               din,
    input  logic               frame_sync,
    output logic [N_SLOTS-1:0] dout,
    output logic               frame_valid,
    output logic               sync_err,
    output logic               locked,
    output logic [SEL_W-1:0]   slot
);

    state_t             r_state;
    state_t             w_next_state;
    logic [N_SLOTS-1:0] r_shadow;
    logic [N_SLOTS-1:0] w_next_shadow;
    logic [N_SLOTS-1:0] r_dout;
    logic [N_SLOTS-1:0] w_next_dout;
    logic               r_frame_valid;
    logic               w_frame_valid;
    logic               r_sync_err;
    logic               w_sync_err;
    logic               r_locked;
    logic               w_cnt_inc;
    logic               w_cnt_load;
    logic               w_cnt_clr;
    logic [SEL_W-1:0]   w_slot;
    logic               w_wrap;

    // Shadow vector holding only the slot-0 bit; used whenever a new frame
    // starts on a sync bit, which also discards any partial frame.
    logic [N_SLOTS-1:0] w_first_bit;
    assign w_first_bit = {{(N_SLOTS-1){1'b0}}, din};

    tdm_slot_counter u_slot_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_cnt_inc),
        .load_one (w_cnt_load),
        .clear    (w_cnt_clr),
        .count    (w_slot),
        .wrap     (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= HUNT;
            r_shadow      <= '0;
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_shadow      <= w_next_shadow;
            r_dout        <= w_next_dout;
            r_frame_valid <= w_frame_valid;
            r_sync_err    <= w_sync_err;
            r_locked      <= (w_next_state == LOCKED);
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_shadow = r_shadow;
        w_next_dout   = r_dout;
        w_frame_valid = 1'b0;
        w_sync_err    = 1'b0;
        w_cnt_inc     = 1'b0;
        w_cnt_load    = 1'b0;
        w_cnt_clr     = 1'b0;

        if (en) begin
            case (r_state)
                HUNT: begin
                    // Data is ignored until a sync bit marks slot 0.
                    if (frame_sync) begin
                        w_next_shadow = w_first_bit;
                        w_cnt_load    = 1'b1;
                        w_next_state  = LOCKED;
                    end
                end

                LOCKED: begin
                    if (w_slot == '0) begin
                        if (frame_sync) begin
                            w_next_shadow = w_first_bit;
                            w_cnt_load    = 1'b1;
                        end else begin
                            // Missing sync: alignment lost.
                            w_sync_err    = 1'b1;
                            w_next_state  = HUNT;
                            w_next_shadow = '0;
                            w_cnt_clr     = 1'b1;
                        end
                    end else if (frame_sync) begin
                        // Early sync: restart the frame from this bit.
                        w_sync_err    = 1'b1;
                        w_next_shadow = w_first_bit;
                        w_cnt_load    = 1'b1;
                    end else begin
                        w_next_shadow[w_slot] = din;
                        w_cnt_inc             = 1'b1;
                        if (w_wrap) begin
                            w_next_dout   = {din, r_shadow[N_SLOTS-2:0]};
                            w_frame_valid = 1'b1;
                        end
                    end
                end

                default: begin
                    w_next_state = HUNT;
                end
            endcase
        end
    end

    assign dout        = r_dout;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = r_locked;
    assign slot        = w_slot;

endmodule : tdm_one_to_eight_demux
`default_nettype wire
